axi4_lite_mgr: RTL and testbench
================================

// Module: axi4_lite_mgr
// PURPOSE
//  AXI4-Lite manager (master) stage upstream of the team's AXI4-Lite subordinate register blocks.
//  Accepts single read/write commands on a simple valid/ready command port and runs one AXI4-Lite
//  transaction on the m_axi_* channels. Returns data/response on a valid/ready response port.
//  One outstanding transaction at a time. A watchdog stops the block hanging on a dead subordinate.
// PARAMETERS
//  C_AXI_DATA_WIDTH  32   AXI data width; also cmd_wdata / rsp_rdata width
//  C_AXI_ADDR_WIDTH  32   AXI address width; also cmd_addr width
//  C_TIMEOUT_CYCLES  256  cycles spent in an AXI wait state before the transaction is abandoned; >=2
// PORTS
//  clk            in   1    clock; all logic on posedge
//  reset          in   1    one clock; reset is synchronous and active-high
//  cmd_valid      in   1    command present
//  cmd_ready      out  1    command accepted when cmd_valid & cmd_ready
//  cmd_write      in   1    1 = write, 0 = read
//  cmd_addr       in   AW   byte address
//  cmd_wdata      in   DW   write data; ignored for reads
//  rsp_valid      out  1    response present
//  rsp_ready      in   1    response consumed when rsp_valid & rsp_ready
//  rsp_rdata      out  DW   read data; 0 for writes and timeouts
//  rsp_resp       out  2    captured RRESP/BRESP, or SLVERR on timeout
//  rsp_timeout    out  1    1 = transaction abandoned by watchdog
//  m_axi_awaddr/awvalid/awready, m_axi_wdata/wvalid/wready, m_axi_bresp/bvalid/bready,
//  m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite manager side
// BEHAVIOUR
//  - All outputs registered. Reset values: every *valid, bready, rready = 0. cmd_ready = 0 during reset, 1 the cycle after.
//    Address, data and rsp_* payloads = 0. State = ST_IDLE. Watchdog = 0.
//  - FSM states:
//    ST_IDLE: cmd_ready=1. On cmd handshake, latch addr/wdata. Write -> ST_WR_REQ: awvalid=wvalid=1 the next cycle.
//      Read -> ST_RD_ADDR: arvalid=1 the next cycle. cmd_ready is 0 in every other state.
//    ST_WR_REQ: awvalid and wvalid drop independently on their own handshake. AW and W may complete in either
//      order or the same cycle. When both are done -> ST_WR_RESP.
//    ST_WR_RESP: bready=1 and held until bvalid. On bvalid, capture bresp, bready<=0 -> ST_RSP.
//    ST_RD_ADDR: arvalid held until arready, then arvalid<=0, rready<=1 -> ST_RD_DATA.
//    ST_RD_DATA: rready held until rvalid. Capture rdata/rresp, rready<=0 -> ST_RSP.
//      The subordinate's single-cycle rvalid must never be missed.
//    ST_RSP: rsp_valid=1 with a stable payload until rsp_ready. Then rsp_valid<=0 -> ST_IDLE.
//      Minimum turnaround: cmd accept -> AXI valid 1 cycle; AXI response -> rsp_valid 1 cycle.
//  - Payload is held stable: AXI payload stays constant while the matching valid is high.
//    rsp_* stays constant while rsp_valid is high.
//  - Watchdog:
//    - Counts every cycle in ST_WR_REQ/ST_WR_RESP/ST_RD_ADDR/ST_RD_DATA. Cleared on entry to any state.
//    - At count == C_TIMEOUT_CYCLES-1: all AXI valids/readies <=0, rsp_resp<=2'b10, rsp_timeout<=1 -> ST_RSP.
//    - Dropping valid without a handshake is the only permitted protocol deviation, and only here.
//    - A handshake in the same cycle as expiry wins; no timeout is raised.
//  - reset mid-transaction: next cycle all outputs at reset values. In-flight command and response are discarded.
//  - No address decode or alignment check; the address passes through unchanged.
// STRUCTURE
//  - Shared package axi4_lite_pkg:
//    - axi_resp_e (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11)
//    - mgr_state_e {ST_IDLE, ST_WR_REQ, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA, ST_RSP}
//    - Later reused by the subordinate.
//  - One sub-module, axi4_lite_wdog: clear/enable/expired counter, width $clog2(C_TIMEOUT_CYCLES).
//  - The FSM and datapath stay in axi4_lite_mgr.
// TESTING
//  1. Paired with the team subordinate: write 0x20 <- 0xDEADBEEF, then read 0x20.
//     -> write rsp_resp=00; read rsp_rdata=0xDEADBEEF, rsp_resp=00, rsp_timeout=0.
//  2. Model awready at cycle 1 and wready at cycle 3 after valid.
//     -> awvalid low after cycle 1; wvalid held to cycle 3; bready rises the cycle after.
//  3. Tie arready=0, issue a read of 0x04 -> arvalid drops after 256 cycles.
//     -> rsp_valid=1, rsp_resp=10, rsp_timeout=1, rsp_rdata=0.
//  4. Hold rsp_ready=0 for 5 cycles after a read returning 0x12345678.
//     -> rsp payload stable, cmd_ready=0, a new cmd_valid is not accepted.
//  5. Assert reset for 1 cycle while in ST_WR_RESP.
//     -> next cycle all valids and bready are 0, rsp_valid=0; cmd_ready=1 the cycle after.
//  6. Back-to-back cmds with rsp_ready=1 tied high.
//     -> every command completes in order; no AXI valid is asserted while the block is in ST_RSP.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes and the manager state encoding.
// The subordinate register blocks import the same package.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RSP
  } mgr_state_e;

  // States in which the manager is waiting on the subordinate.
  function automatic logic is_wait_state(input mgr_state_e s);
    return (s == ST_WR_REQ) || (s == ST_WR_RESP) || (s == ST_RD_ADDR) || (s == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/axi4_lite_wdog.sv
// Watchdog counter: clears on request, counts while enabled, and flags the
// last permitted wait cycle so the manager can abandon a stuck transaction.
module axi4_lite_wdog #(
  parameter int C_TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(C_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(C_TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/axi4_lite_mgr.sv
// AXI4-Lite manager: turns one command from the valid/ready command port into a
// single AXI4-Lite read or write, then returns the result on the response port.
module axi4_lite_mgr
  import axi4_lite_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  // command port
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0] cmd_wdata,
  // response port
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [C_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_timeout,
  // AXI4-Lite write address / data / response
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  // AXI4-Lite read address / data
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [C_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  mgr_state_e                  state_q, state_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                        awvalid_q, awvalid_d;
  logic                        wvalid_q, wvalid_d;
  logic                        bready_q, bready_d;
  logic                        arvalid_q, arvalid_d;
  logic                        rready_q, rready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [C_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  axi_resp_e                   rsp_resp_q, rsp_resp_d;
  logic                        rsp_timeout_q, rsp_timeout_d;

  logic wd_clear, wd_enable, wd_expired;
  logic abandon;
  logic aw_done, w_done;

  axi4_lite_wdog #(
    .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // A channel is done once its valid has dropped or it handshakes this cycle.
  assign aw_done = !awvalid_q || m_axi_awready;
  assign w_done  = !wvalid_q  || m_axi_wready;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    abandon       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end

      ST_WR_REQ: begin
        if (aw_done && w_done) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = ST_WR_RESP;
        end else if (wd_expired) begin
          abandon = 1'b1;
        end else begin
          awvalid_d = awvalid_q && !m_axi_awready;
          wvalid_d  = wvalid_q && !m_axi_wready;
        end
      end

      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = axi_resp_e'(m_axi_bresp);
          rsp_timeout_d = 1'b0;
          state_d       = ST_RSP;
        end else if (wd_expired) begin
          abandon = 1'b1;
        end
      end

      ST_RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end else if (wd_expired) begin
          abandon = 1'b1;
        end
      end

      // rready is already high on entry, so a one-cycle rvalid is always caught.
      ST_RD_DATA: begin
        if (m_axi_rvalid) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = m_axi_rdata;
          rsp_resp_d    = axi_resp_e'(m_axi_rresp);
          rsp_timeout_d = 1'b0;
          state_d       = ST_RSP;
        end else if (wd_expired) begin
          abandon = 1'b1;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Watchdog expiry without a handshake: withdraw from the bus and report SLVERR.
    if (abandon) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = SLVERR;
      rsp_timeout_d = 1'b1;
      state_d       = ST_RSP;
    end

    cmd_ready_d = (state_d == ST_IDLE);
    wd_clear    = (state_d != state_q);
    wd_enable   = is_wait_state(state_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= OKAY;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_mgr.sv
// Bench for axi4_lite_mgr: a latency-configurable subordinate model plus a vector
// table of transactions and hand-written sequences for timing, reset and back-to-back.
module tb_axi4_lite_mgr;
  import axi4_lite_pkg::*;

  localparam int DEAD = 100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  axi4_lite_mgr #(
    .C_AXI_DATA_WIDTH(32),
    .C_AXI_ADDR_WIDTH(32),
    .C_TIMEOUT_CYCLES(256)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  // ---------------- subordinate model ----------------
  int          cfg_aw_lat, cfg_w_lat, cfg_b_lat, cfg_ar_lat, cfg_r_lat;
  logic [1:0]  cfg_resp;
  logic        aw_hs_q, w_hs_q, b_hs_q, ar_hs_q, r_hs_q;
  logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
  logic [31:0] mem [int];
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        got_aw, got_w, got_ar;

  always @(posedge clk) begin
    aw_hs_q <= m_axi_awvalid && m_axi_awready;
    w_hs_q  <= m_axi_wvalid && m_axi_wready;
    b_hs_q  <= m_axi_bvalid && m_axi_bready;
    ar_hs_q <= m_axi_arvalid && m_axi_arready;
    r_hs_q  <= m_axi_rvalid && m_axi_rready;
    if (m_axi_awvalid && m_axi_awready) aw_addr_l <= m_axi_awaddr;
    if (m_axi_wvalid && m_axi_wready) w_data_l <= m_axi_wdata;
    if (m_axi_arvalid && m_axi_arready) ar_addr_l <= m_axi_araddr;
  end

  // Drives at negedge; the model forgets everything while the manager is idle or in reset.
  always @(negedge clk) begin
    if (reset || cmd_ready) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      got_aw = 0; got_w = 0; got_ar = 0;
    end else begin
      if (aw_hs_q) begin m_axi_awready = 0; got_aw = 1; end
      else if (!m_axi_awvalid) begin m_axi_awready = 0; aw_cnt = 0; end
      else if (!m_axi_awready) begin
        if (aw_cnt == cfg_aw_lat) m_axi_awready = 1; else aw_cnt++;
      end
      if (w_hs_q) begin m_axi_wready = 0; got_w = 1; end
      else if (!m_axi_wvalid) begin m_axi_wready = 0; w_cnt = 0; end
      else if (!m_axi_wready) begin
        if (w_cnt == cfg_w_lat) m_axi_wready = 1; else w_cnt++;
      end
      if (ar_hs_q) begin m_axi_arready = 0; got_ar = 1; end
      else if (!m_axi_arvalid) begin m_axi_arready = 0; ar_cnt = 0; end
      else if (!m_axi_arready) begin
        if (ar_cnt == cfg_ar_lat) m_axi_arready = 1; else ar_cnt++;
      end
      if (b_hs_q) m_axi_bvalid = 0;
      else if (got_aw && got_w && !m_axi_bvalid) begin
        if (b_cnt == cfg_b_lat) begin
          m_axi_bvalid = 1; m_axi_bresp = cfg_resp; got_aw = 0; got_w = 0; b_cnt = 0;
          if (cfg_resp == 2'b00 || cfg_resp == 2'b01) mem[int'(aw_addr_l[9:2])] = w_data_l;
        end else b_cnt++;
      end
      if (r_hs_q) m_axi_rvalid = 0;
      else if (got_ar && !m_axi_rvalid) begin
        if (r_cnt == cfg_r_lat) begin
          m_axi_rvalid = 1; m_axi_rresp = cfg_resp; got_ar = 0; r_cnt = 0;
          m_axi_rdata = mem.exists(int'(ar_addr_l[9:2])) ? mem[int'(ar_addr_l[9:2])] : 32'h0;
        end else r_cnt++;
      end
    end
  end

  // Any AXI valid/ready while a response is pending is a protocol fault of the manager.
  int rsp_axi_viol = 0;
  always @(negedge clk) begin
    if (!reset && rsp_valid &&
        (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid || m_axi_bready || m_axi_rready))
      rsp_axi_viol++;
  end

  // ---------------- checking ----------------
  int   checks = 0;
  int   failures = 0;
  logic rsp_tie = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int aw, input int w, input int b, input int ar, input int r,
                         input logic [1:0] resp);
    cfg_aw_lat = aw; cfg_w_lat = w; cfg_b_lat = b; cfg_ar_lat = ar; cfg_r_lat = r;
    cfg_resp = resp;
  endtask

  // Called at a negedge; returns at the negedge just after the command handshake.
  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_accepted", {63'h0, cmd_ready}, 64'h1);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic finish_rsp(input string tag, input int hold, input logic [31:0] exp_rdata,
                            input logic [1:0] exp_resp, input logic exp_to);
    int n = 0;
    logic [35:0] snap;
    while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
    check({tag, "_rsp_valid"}, {63'h0, rsp_valid}, 64'h1);
    check({tag, "_rdata"}, {32'h0, rsp_rdata}, {32'h0, exp_rdata});
    check({tag, "_resp"}, {62'h0, rsp_resp}, {62'h0, exp_resp});
    check({tag, "_timeout"}, {63'h0, rsp_timeout}, {63'h0, exp_to});
    if (!rsp_tie) begin
      snap = {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata};
      for (int i = 0; i < hold; i++) begin
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h3C;
        @(negedge clk);
        check({tag, "_hold_payload"}, {28'h0, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata},
              {28'h0, snap});
        check({tag, "_hold_cmd_ready"}, {63'h0, cmd_ready}, 64'h0);
      end
      cmd_valid = 0; rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      check({tag, "_rsp_consumed"}, {63'h0, rsp_valid}, 64'h0);
      if (hold > 0)
        check({tag, "_no_sneak_cmd"}, {62'h0, m_axi_awvalid, m_axi_arvalid}, 64'h0);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          aw_lat, w_lat, b_lat, ar_lat, r_lat;
    logic [1:0]  sresp;
    int          hold;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_to;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int aw_hi, w_hi, first_b, first_rsp;

    //          wr    addr    wdata          aw   w    b    ar   r    sresp  hold rdata          resp   to
    vecs[0]  = '{1'b1, 32'h20, 32'hDEADBEEF, 0,   0,   0,   0,   0,   2'b00, 0,   32'h0,         2'b00, 1'b0};
    vecs[1]  = '{1'b0, 32'h20, 32'h0,        0,   0,   0,   0,   0,   2'b00, 0,   32'hDEADBEEF,  2'b00, 1'b0};
    vecs[2]  = '{1'b1, 32'h24, 32'h12345678, 1,   3,   2,   0,   0,   2'b00, 0,   32'h0,         2'b00, 1'b0};
    vecs[3]  = '{1'b0, 32'h24, 32'h0,        0,   0,   0,   2,   3,   2'b00, 5,   32'h12345678,  2'b00, 1'b0};
    vecs[4]  = '{1'b1, 32'h28, 32'hA5A5A5A5, 0,   0,   0,   0,   0,   2'b10, 0,   32'h0,         2'b10, 1'b0};
    vecs[5]  = '{1'b0, 32'h28, 32'h0,        0,   0,   0,   0,   0,   2'b00, 0,   32'h0,         2'b00, 1'b0};
    vecs[6]  = '{1'b0, 32'h20, 32'h0,        0,   0,   0,   1,   1,   2'b11, 0,   32'hDEADBEEF,  2'b11, 1'b0};
    vecs[7]  = '{1'b0, 32'h04, 32'h0,        0,   0,   0,   DEAD,0,   2'b00, 0,   32'h0,         2'b10, 1'b1};
    vecs[8]  = '{1'b1, 32'h2C, 32'h0BADF00D, 0,   DEAD,0,   0,   0,   2'b00, 0,   32'h0,         2'b10, 1'b1};
    vecs[9]  = '{1'b1, 32'h30, 32'hCAFEF00D, 0,   0,   DEAD,0,   0,   2'b00, 0,   32'h0,         2'b10, 1'b1};
    vecs[10] = '{1'b0, 32'h2C, 32'h0,        0,   0,   0,   0,   0,   2'b00, 0,   32'h0,         2'b00, 1'b0};
    vecs[11] = '{1'b0, 32'h20, 32'h0,        0,   0,   0,   255, 0,   2'b00, 0,   32'hDEADBEEF,  2'b00, 1'b0};
    vecs[12] = '{1'b0, 32'h20, 32'h0,        0,   0,   0,   256, 0,   2'b00, 0,   32'h0,         2'b10, 1'b1};
    vecs[13] = '{1'b0, 32'h24, 32'h0,        0,   0,   0,   0,   255, 2'b00, 0,   32'h12345678,  2'b00, 1'b0};
    vecs[14] = '{1'b1, 32'h34, 32'h00C0FFEE, 0,   0,   255, 0,   0,   2'b01, 0,   32'h0,         2'b01, 1'b0};

    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    set_cfg(0, 0, 0, 0, 0, 2'b00);
    reset = 1;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", {63'h0, cmd_ready}, 64'h0);
    check("rst_valids", {58'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                         m_axi_rready, rsp_valid}, 64'h0);
    check("rst_payload", {m_axi_awaddr, m_axi_wdata}, 64'h0);
    check("rst_rsp", {29'h0, rsp_timeout, rsp_resp, rsp_rdata}, 64'h0);
    reset = 0;
    @(negedge clk);
    check("post_rst_cmd_ready", {63'h0, cmd_ready}, 64'h1);

    for (int i = 0; i < 15; i++) begin
      set_cfg(vecs[i].aw_lat, vecs[i].w_lat, vecs[i].b_lat, vecs[i].ar_lat, vecs[i].r_lat,
              vecs[i].sresp);
      issue_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      finish_rsp($sformatf("vec%0d", i), vecs[i].hold, vecs[i].exp_rdata, vecs[i].exp_resp,
                 vecs[i].exp_to);
    end

    // awready one cycle after valid, wready three cycles after valid.
    set_cfg(1, 3, 0, 0, 0, 2'b00);
    issue_cmd(1'b1, 32'h38, 32'h01020304);
    check("t2_aw_turnaround", {63'h0, m_axi_awvalid}, 64'h1);
    aw_hi = 0; w_hi = 0; first_b = -1; first_rsp = -1;
    for (int k = 0; k < 10; k++) begin
      if (m_axi_awvalid) aw_hi++;
      if (m_axi_wvalid) w_hi++;
      if (m_axi_bready && first_b < 0) first_b = k;
      if (rsp_valid && first_rsp < 0) first_rsp = k;
      @(negedge clk);
    end
    check("t2_awvalid_cycles", 64'(aw_hi), 64'd2);
    check("t2_wvalid_cycles", 64'(w_hi), 64'd4);
    check("t2_bready_first", 64'(first_b), 64'd4);
    check("t2_rsp_first", 64'(first_rsp), 64'd5);
    finish_rsp("t2", 0, 32'h0, 2'b00, 1'b0);

    // Reset while waiting for BVALID.
    set_cfg(0, 0, DEAD, 0, 0, 2'b00);
    issue_cmd(1'b1, 32'h50, 32'h55);
    n = 0;
    while (!m_axi_bready && n < 20) begin @(negedge clk); n++; end
    check("t5_in_wr_resp", {63'h0, m_axi_bready}, 64'h1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("t5_outputs_cleared", {57'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                 m_axi_rready, rsp_valid, cmd_ready}, 64'h0);
    @(negedge clk);
    check("t5_cmd_ready_after", {63'h0, cmd_ready}, 64'h1);
    repeat (3) @(negedge clk);
    check("t5_rsp_discarded", {63'h0, rsp_valid}, 64'h0);

    // Back-to-back with rsp_ready tied high.
    set_cfg(0, 0, 0, 0, 0, 2'b00);
    rsp_tie = 1; rsp_ready = 1;
    issue_cmd(1'b1, 32'h40, 32'h11111111); finish_rsp("b2b0", 0, 32'h0, 2'b00, 1'b0);
    issue_cmd(1'b0, 32'h40, 32'h0);        finish_rsp("b2b1", 0, 32'h11111111, 2'b00, 1'b0);
    issue_cmd(1'b1, 32'h44, 32'h22222222); finish_rsp("b2b2", 0, 32'h0, 2'b00, 1'b0);
    issue_cmd(1'b0, 32'h44, 32'h0);        finish_rsp("b2b3", 0, 32'h22222222, 2'b00, 1'b0);
    issue_cmd(1'b0, 32'h34, 32'h0);        finish_rsp("b2b4", 0, 32'h00C0FFEE, 2'b00, 1'b0);
    @(negedge clk);
    rsp_tie = 0; rsp_ready = 0;
    repeat (2) @(negedge clk);
    check("axi_active_during_rsp", 64'(rsp_axi_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
